// File: rtl/if_id_ex_trace_tracker.sv
// rtl/if_id_ex_trace_tracker.sv - IF/ID/EX stage timestamp tracer emitting one record per instruction.
// Optional wrong-path flush on jump_done: define TRACE_JUMP_FLUSH_EN.
module if_id_ex_trace_tracker #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_grant,
  input  logic                  instr_rvalid,
  input  logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic                  is_decoding,
  input  logic                  id_ready,
  input  logic                  jump_done,
  input  logic                  ex_ready,
  output logic                  trace_data_ready,
  output logic [ADDR_WIDTH-1:0] trace_addr,
  output logic [DATA_WIDTH-1:0] trace_instr,
  output logic [31:0]           if_start,
  output logic [31:0]           if_end,
  output logic [31:0]           id_start,
  output logic [31:0]           id_end,
  output logic [31:0]           ex_start,
  output logic [31:0]           ex_end,
  output logic                  overflow
);
  localparam int PW = $clog2(BUFFER_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0]           if_start;
    logic [31:0]           if_end;
  } fetch_rec_t;

  logic [31:0]           counter;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [31:0]           pend_ts;
  fetch_rec_t            mem [BUFFER_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_next;
  logic [PW:0]           count;
  logic                  id_active;
  logic [31:0]           id_start_ts;
  logic                  ex_valid;
  fetch_rec_t            ex_rec;
  logic [31:0]           ex_id_start, ex_id_end, ex_ex_start;

  logic flush, push_req, push_ok, capture, pop, drop, keep;
  logic fifo_empty, fifo_full, ex_free, id_xfer;

`ifdef TRACE_JUMP_FLUSH_EN
  assign flush = jump_done;
`else
  logic unused_jump_done;
  assign flush            = 1'b0;
  assign unused_jump_done = jump_done;
`endif

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == (PW+1)'(BUFFER_DEPTH));
  // A new grant is accepted in the same cycle the outstanding fetch returns.
  assign push_req    = instr_rvalid & pending & ~flush;
  assign capture     = instr_req & instr_grant & (~pending | instr_rvalid) & ~flush;
  assign ex_free     = ex_valid & ex_ready;
  assign id_xfer     = id_active & id_ready & (~ex_valid | ex_free);
  assign pop         = id_xfer;
  assign push_ok     = push_req & (~fifo_full | pop);
  assign drop        = push_req & fifo_full & ~pop;
  assign keep        = id_active & ~pop;
  assign rd_ptr_next = pop ? rd_ptr + PW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{pend_addr, instr_rdata, pend_ts, counter};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter     <= 32'hFFFF_FFFF;
      pending     <= 1'b0;
      pend_addr   <= '0;
      pend_ts     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      id_active   <= 1'b0;
      id_start_ts <= '0;
    end else begin
      counter <= counter + 32'd1;

      if (flush) begin
        pending <= 1'b0;
      end else if (capture) begin
        pending   <= 1'b1;
        pend_addr <= instr_addr;
        pend_ts   <= counter;
      end else if (push_req) begin
        pending <= 1'b0;
      end

      // On a flush only an already-active head survives.
      if (flush) begin
        rd_ptr <= rd_ptr_next;
        wr_ptr <= rd_ptr_next + PW'(keep);
        count  <= (PW+1)'(keep);
      end else begin
        rd_ptr <= rd_ptr_next;
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
      end

      if (drop) overflow <= 1'b1;

      if (id_xfer) begin
        id_active <= 1'b0;
      end else if (~fifo_empty & is_decoding & ~id_active & ~flush) begin
        id_active   <= 1'b1;
        id_start_ts <= counter;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid         <= 1'b0;
      ex_rec           <= '0;
      ex_id_start      <= '0;
      ex_id_end        <= '0;
      ex_ex_start      <= '0;
      trace_data_ready <= 1'b0;
      trace_addr       <= '0;
      trace_instr      <= '0;
      if_start         <= '0;
      if_end           <= '0;
      id_start         <= '0;
      id_end           <= '0;
      ex_start         <= '0;
      ex_end           <= '0;
    end else begin
      if (id_xfer) begin
        ex_valid    <= 1'b1;
        ex_rec      <= mem[rd_ptr];
        ex_id_start <= id_start_ts;
        ex_id_end   <= counter;
        ex_ex_start <= counter + 32'd1;
      end else if (ex_free) begin
        ex_valid <= 1'b0;
      end

      trace_data_ready <= ex_free;
      if (ex_free) begin
        trace_addr  <= ex_rec.addr;
        trace_instr <= ex_rec.instr;
        if_start    <= ex_rec.if_start;
        if_end      <= ex_rec.if_end;
        id_start    <= ex_id_start;
        id_end      <= ex_id_end;
        ex_start    <= ex_ex_start;
        ex_end      <= counter;
      end
    end
  end
endmodule

// File: tb/tb_if_id_ex_trace_tracker.sv
// tb/tb_if_id_ex_trace_tracker.sv - Scoreboard bench for if_id_ex_trace_tracker.
module tb_if_id_ex_trace_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0, instr_grant = 1'b0, instr_rvalid = 1'b0;
  logic [31:0] instr_addr = '0, instr_rdata = '0;
  logic        is_decoding = 1'b0, id_ready = 1'b0, jump_done = 1'b0, ex_ready = 1'b0;
  logic        trace_data_ready, overflow;
  logic [31:0] trace_addr, trace_instr;
  logic [31:0] if_start, if_end, id_start, id_end, ex_start, ex_end;

  typedef struct {
    logic [31:0] addr, instr, ifs, ife, ids, ide, exs, exe;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        fq[$];
  rec_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          rec_seen = 0;
  int          base;
  logic [31:0] tb_cnt;

  if_id_ex_trace_tracker dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_grant(instr_grant),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .is_decoding(is_decoding), .id_ready(id_ready), .jump_done(jump_done),
    .ex_ready(ex_ready),
    .trace_data_ready(trace_data_ready), .trace_addr(trace_addr),
    .trace_instr(trace_instr),
    .if_start(if_start), .if_end(if_end), .id_start(id_start), .id_end(id_end),
    .ex_start(ex_start), .ex_end(ex_end), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 32'hFFFF_FFFF;
    else     tb_cnt <= tb_cnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && trace_data_ready) begin
      chk("record_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("trace_addr",  trace_addr,  mon_e.addr);
        chk("trace_instr", trace_instr, mon_e.instr);
        chk("if_start",    if_start,    mon_e.ifs);
        chk("if_end",      if_end,      mon_e.ife);
        chk("id_start",    id_start,    mon_e.ids);
        chk("id_end",      id_end,      mon_e.ide);
        chk("ex_start",    ex_start,    mon_e.exs);
        chk("ex_end",      ex_end,      mon_e.exe);
      end
      rec_seen++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    instr_req = 0; instr_grant = 0; instr_rvalid = 0;
    is_decoding = 0; id_ready = 0; jump_done = 0; ex_ready = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete();
    fq.delete();
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    rec_t r;
    r = '{default: '0};
    r.addr = a; r.instr = d;
    instr_req = 1; instr_grant = 1; instr_addr = a; r.ifs = tb_cnt;
    cyc();
    instr_rvalid = 1; instr_rdata = d; r.ife = tb_cnt;
    cyc();
    fq.push_back(r);
  endtask

  task automatic decode_one(input bit skip_start);
    rec_t r;
    r = fq.pop_front();
    if (!skip_start) begin
      is_decoding = 1; r.ids = tb_cnt;
      cyc();
    end
    id_ready = 1; r.ide = tb_cnt; r.exs = tb_cnt + 1;
    cyc();
    ex_ready = 1; r.exe = tb_cnt;
    exp_q.push_back(r);
    cyc();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    cyc();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rec_t ra, rb;

    // Reset state and idle
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_ready",    32'(trace_data_ready), 32'd0);
      chk("idle_overflow", 32'(overflow),         32'd0);
    end
    chk("idle_addr",  trace_addr,  32'd0);
    chk("idle_instr", trace_instr, 32'd0);
    chk("idle_ts",    if_start | if_end | id_start | id_end | ex_start | ex_end, 32'd0);

    // Single instruction with absolute timestamps
    reset_dut();
    cyc(); cyc(); cyc();
    instr_req = 1; instr_grant = 1; instr_addr = 32'h80;
    cyc();
    instr_rvalid = 1; instr_rdata = 32'h13;
    cyc();
    is_decoding = 1;
    cyc();
    id_ready = 1;
    cyc();
    cyc();
    ex_ready = 1;
    exp_q.push_back('{32'h80, 32'h13, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
    cyc();
    cyc();
    chk("pulse_width", 32'(trace_data_ready), 32'd0);
    chk("hold_addr",   trace_addr,            32'h80);
    wait_drain("single_drain");

    // Back-to-back fetches: rvalid and next grant in the same cycle
    reset_dut();
    cyc();
    ra = '{default: '0}; rb = '{default: '0};
    ra.addr = 32'h80; ra.instr = 32'hAAAA_0001;
    rb.addr = 32'h84; rb.instr = 32'hBBBB_0002;
    instr_req = 1; instr_grant = 1; instr_addr = ra.addr; ra.ifs = tb_cnt;
    cyc();
    instr_rvalid = 1; instr_rdata = ra.instr; ra.ife = tb_cnt;
    instr_req = 1; instr_grant = 1; instr_addr = rb.addr; rb.ifs = tb_cnt;
    cyc();
    instr_rvalid = 1; instr_rdata = rb.instr; rb.ife = tb_cnt;
    cyc();
    fq.push_back(ra); fq.push_back(rb);
    decode_one(0);
    decode_one(0);
    wait_drain("b2b_drain");

    // Overflow: 9 fetches into an 8-deep buffer
    reset_dut();
    cyc();
    for (int i = 0; i < 8; i++) fetch(32'h100 + 32'(4 * i), $urandom);
    chk("overflow_before", 32'(overflow), 32'd0);
    fetch(32'h120, $urandom);
    chk("overflow_after", 32'(overflow), 32'd1);
    void'(fq.pop_back());
    base = rec_seen;
    for (int i = 0; i < 8; i++) decode_one(0);
    wait_drain("overflow_drain");
    chk("overflow_count", 32'(rec_seen - base), 32'd8);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    reset_dut();
    chk("overflow_reset", 32'(overflow), 32'd0);

    // EX stall: next instruction's id_end lands on the slot-free cycle
    cyc();
    fetch(32'h200, 32'h0000_0093);
    fetch(32'h204, 32'h0000_0113);
    ra = fq.pop_front(); rb = fq.pop_front();
    is_decoding = 1; ra.ids = tb_cnt;
    cyc();
    id_ready = 1; ra.ide = tb_cnt; ra.exs = tb_cnt + 1;
    cyc();
    is_decoding = 1; rb.ids = tb_cnt;
    cyc();
    for (int i = 0; i < 3; i++) begin
      id_ready = 1;
      cyc();
    end
    id_ready = 1; ex_ready = 1; ra.exe = tb_cnt; rb.ide = tb_cnt; rb.exs = tb_cnt + 1;
    exp_q.push_back(ra);
    cyc();
    ex_ready = 1; rb.exe = tb_cnt;
    exp_q.push_back(rb);
    cyc();
    wait_drain("stall_drain");

    // Jump with an active head and two buffered prefetches
    reset_dut();
    cyc();
    fetch(32'h300, 32'h11);
    fetch(32'h304, 32'h22);
    fetch(32'h308, 32'h33);
    ra = fq.pop_front();
    is_decoding = 1; ra.ids = tb_cnt;
    cyc();
    jump_done = 1;
    cyc();
`ifdef TRACE_JUMP_FLUSH_EN
    fq.delete();
`endif
    fq.push_front(ra);
    fetch(32'h400, 32'h44);
    base = rec_seen;
    decode_one(1);
    while (fq.size() != 0) decode_one(0);
    wait_drain("jump_drain");
`ifdef TRACE_JUMP_FLUSH_EN
    chk("jump_count", 32'(rec_seen - base), 32'd2);
`else
    chk("jump_count", 32'(rec_seen - base), 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
